// File: rtl/imem_load_arbiter_pkg.sv
// Shared definitions for the instruction-memory load arbiter: state encoding
// and default geometry of the instruction memory array.
package imem_load_arbiter_pkg;

  localparam int INSTR_WIDTH_DEF = 32;
  localparam int INSTR_DEPTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF  = $clog2(INSTR_DEPTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERROR = 2'd3
  } arb_state_e;

  // The loader owns the port in both IDLE and LOAD.
  function automatic logic is_loading(input arb_state_e st);
    return (st == ST_IDLE) || (st == ST_LOAD);
  endfunction

endpackage

// File: rtl/imem_load_arbiter.sv
// Arbitrates the single instruction-memory port between the streaming program
// loader (while loading) and the CPU fetch path (while running).
module imem_load_arbiter
  import imem_load_arbiter_pkg::*;
#(
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int INSTR_DEPTH = INSTR_DEPTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ld_valid,
  input  logic [INSTR_WIDTH-1:0] ld_data,
  input  logic                   ld_last,
  output logic                   ld_ready,
  input  logic                   reload,
  input  logic [INSTR_WIDTH-1:0] pc,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic                   cpu_run,
  output logic [ADDR_WIDTH:0]    word_count,
  output logic                   load_err,
  output logic                   fetch_fault
);

  localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH+1)'(INSTR_DEPTH - 1);

  arb_state_e                state_r, state_nxt_s;
  logic [ADDR_WIDTH:0]       wr_ptr_r, wr_ptr_nxt_s;
  logic [ADDR_WIDTH:0]       word_count_r, word_count_nxt_s;
  logic                      load_err_r, load_err_nxt_s;
  logic                      fetch_fault_r, fetch_fault_nxt_s;
  logic                      cpu_run_r;
  logic                      ld_ready_s;
  logic                      accept_s;
  logic                      pc_bad_s;
  logic [INSTR_WIDTH-3:0]    pc_word_s;

  // Reset and reload both win over a loader beat in the same cycle.
  assign ld_ready_s = rst_n && !reload && is_loading(state_r);
  assign accept_s   = ld_valid && ld_ready_s;

  assign pc_word_s = pc[INSTR_WIDTH-1:2];
  assign pc_bad_s  = (pc[1:0] != 2'b00) ||
                     (pc_word_s >= (INSTR_WIDTH-2)'(word_count_r));

  assign ld_ready    = ld_ready_s;
  assign mem_we      = accept_s;
  assign mem_wdata   = ld_data;
  assign cpu_run     = cpu_run_r;
  assign word_count  = word_count_r;
  assign load_err    = load_err_r;
  assign fetch_fault = fetch_fault_r;

  // Port address mux: PC word index while running, write pointer otherwise.
  always_comb begin
    mem_addr = wr_ptr_r[ADDR_WIDTH-1:0];
    if (state_r == ST_RUN) begin
      mem_addr = pc[ADDR_WIDTH+1:2];
    end else begin
      mem_addr = wr_ptr_r[ADDR_WIDTH-1:0];
    end
  end

  // Next-state, pointer and flag update logic.
  always_comb begin
    state_nxt_s       = state_r;
    wr_ptr_nxt_s      = wr_ptr_r;
    word_count_nxt_s  = word_count_r;
    load_err_nxt_s    = load_err_r;
    fetch_fault_nxt_s = fetch_fault_r;
    case (state_r)
      ST_IDLE, ST_LOAD: begin
        if (reload) begin
          wr_ptr_nxt_s     = '0;
          word_count_nxt_s = '0;
          state_nxt_s      = ST_IDLE;
        end else if (accept_s) begin
          if (ld_last) begin
            word_count_nxt_s = wr_ptr_r + 1'b1;
            wr_ptr_nxt_s     = wr_ptr_r + 1'b1;
            state_nxt_s      = ST_RUN;
          end else if (wr_ptr_r == LAST_PTR) begin
            // Array full with no terminating word: pointer is held, not wrapped.
            load_err_nxt_s = 1'b1;
            state_nxt_s    = ST_ERROR;
          end else begin
            wr_ptr_nxt_s = wr_ptr_r + 1'b1;
            state_nxt_s  = ST_LOAD;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (reload) begin
          wr_ptr_nxt_s      = '0;
          word_count_nxt_s  = '0;
          fetch_fault_nxt_s = 1'b0;
          state_nxt_s       = ST_IDLE;
        end else if (pc_bad_s) begin
          fetch_fault_nxt_s = 1'b1;
        end else begin
          fetch_fault_nxt_s = fetch_fault_r;
        end
      end
      ST_ERROR: begin
        if (reload) begin
          load_err_nxt_s   = 1'b0;
          wr_ptr_nxt_s     = '0;
          word_count_nxt_s = '0;
          state_nxt_s      = ST_IDLE;
        end else begin
          state_nxt_s = ST_ERROR;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset; cpu_run follows the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      wr_ptr_r      <= '0;
      word_count_r  <= '0;
      load_err_r    <= 1'b0;
      fetch_fault_r <= 1'b0;
      cpu_run_r     <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      wr_ptr_r      <= wr_ptr_nxt_s;
      word_count_r  <= word_count_nxt_s;
      load_err_r    <= load_err_nxt_s;
      fetch_fault_r <= fetch_fault_nxt_s;
      cpu_run_r     <= (state_nxt_s == ST_RUN);
    end
  end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Self-checking bench for imem_load_arbiter: directed vector table, hand-written
// overflow / single-word sequences, and randomized traffic against a reference model.
module tb_imem_load_arbiter;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_valid;
  logic [W-1:0]  ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          reload;
  logic [W-1:0]  pc;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic          cpu_run;
  logic [AW:0]   word_count;
  logic          load_err;
  logic          fetch_fault;

  imem_load_arbiter #(.INSTR_WIDTH(W), .INSTR_DEPTH(D), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .reload(reload), .pc(pc),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_run(cpu_run), .word_count(word_count), .load_err(load_err),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // Storage array driven by the arbiter's write port.
  logic [W-1:0] imem [D];
  always @(posedge clk) if (mem_we) imem[mem_addr] <= mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: program words written so far, and run/error/fault status.
  logic [W-1:0] exp_mem [D];
  bit m_run, m_err, m_fault, m_cpu_run;
  int m_ptr, m_count;

  typedef struct {
    logic rst_n, valid; logic [W-1:0] data; logic last, rl; logic [W-1:0] pcv;
    logic e_ready, e_we; logic [AW-1:0] e_addr; logic e_run; logic [AW:0] e_wc;
    logic e_err, e_ff;
  } vec_t;
  vec_t tab [18];

  function automatic vec_t mk(logic r, logic v, logic [W-1:0] d, logic l, logic rl,
                              logic [W-1:0] p, logic rdy, logic we, logic [AW-1:0] a,
                              logic run, logic [AW:0] wc, logic er, logic ff);
    vec_t t;
    t.rst_n = r; t.valid = v; t.data = d; t.last = l; t.rl = rl; t.pcv = p;
    t.e_ready = rdy; t.e_we = we; t.e_addr = a; t.e_run = run; t.e_wc = wc;
    t.e_err = er; t.e_ff = ff;
    return t;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [W-1:0] d,
                       input logic l, input logic rl, input logic [W-1:0] p);
    rst_n = r; ld_valid = v; ld_data = d; ld_last = l; reload = rl; pc = p;
  endtask

  task automatic check_model();
    logic e_ready;
    logic [AW-1:0] e_addr;
    e_ready = rst_n && !reload && !m_run && !m_err;
    e_addr  = m_run ? AW'(pc >> 2) : AW'(m_ptr);
    chk("m_ld_ready", W'(ld_ready), W'(e_ready));
    chk("m_mem_we", W'(mem_we), W'(e_ready && ld_valid));
    chk("m_mem_wdata", mem_wdata, ld_data);
    chk("m_mem_addr", W'(mem_addr), W'(e_addr));
    chk("m_cpu_run", W'(cpu_run), W'(m_cpu_run));
    chk("m_word_count", W'(word_count), W'(m_count));
    chk("m_load_err", W'(load_err), W'(m_err));
    chk("m_fetch_fault", W'(fetch_fault), W'(m_fault));
  endtask

  // One clock edge; the model applies the rules to the inputs held across it.
  task automatic advance();
    @(posedge clk);
    if (!rst_n) begin
      m_run = 0; m_err = 0; m_fault = 0; m_ptr = 0; m_count = 0;
    end else if (reload) begin
      m_run = 0; m_err = 0; m_fault = 0; m_ptr = 0; m_count = 0;
    end else if (m_run) begin
      if (pc[1:0] != 2'b00 || (pc >> 2) >= W'(m_count)) m_fault = 1;
    end else if (!m_err && ld_valid) begin
      exp_mem[m_ptr] = ld_data;
      if (ld_last) begin
        m_count = m_ptr + 1; m_ptr = m_ptr + 1; m_run = 1;
      end else if (m_ptr == D - 1) begin
        m_err = 1;
      end else begin
        m_ptr = m_ptr + 1;
      end
    end
    m_cpu_run = m_run;
    #1;
  endtask

  task automatic cyc(input logic r, input logic v, input logic [W-1:0] d,
                     input logic l, input logic rl, input logic [W-1:0] p);
    drive(r, v, d, l, rl, p);
    #2;
    check_model();
    advance();
  endtask

  initial begin
    logic [W-1:0] rp;
    for (int i = 0; i < D; i++) begin imem[i] = '0; exp_mem[i] = '0; end
    m_run = 0; m_err = 0; m_fault = 0; m_cpu_run = 0; m_ptr = 0; m_count = 0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;

    //            rst v  data          l  rl pc     | rdy we addr run wc err ff
    tab[0]  = mk(0, 1, 32'h1111_1111, 0, 0, 32'h0,  0, 0, 5'd0, 0, 6'd0, 0, 0);
    tab[1]  = mk(0, 1, 32'h1111_1111, 0, 0, 32'h0,  0, 0, 5'd0, 0, 6'd0, 0, 0);
    tab[2]  = mk(0, 1, 32'h1111_1111, 0, 0, 32'h0,  0, 0, 5'd0, 0, 6'd0, 0, 0);
    tab[3]  = mk(1, 0, 32'h0,         0, 0, 32'h0,  1, 0, 5'd0, 0, 6'd0, 0, 0);
    tab[4]  = mk(1, 1, 32'h2008_0005, 0, 0, 32'h0,  1, 1, 5'd0, 0, 6'd0, 0, 0);
    tab[5]  = mk(1, 1, 32'h2009_0003, 0, 0, 32'h0,  1, 1, 5'd1, 0, 6'd0, 0, 0);
    tab[6]  = mk(1, 0, 32'h0,         0, 0, 32'h0,  1, 0, 5'd2, 0, 6'd0, 0, 0);
    tab[7]  = mk(1, 1, 32'h0109_5020, 0, 0, 32'h0,  1, 1, 5'd2, 0, 6'd0, 0, 0);
    tab[8]  = mk(1, 1, 32'h0800_0000, 1, 0, 32'h0,  1, 1, 5'd3, 0, 6'd0, 0, 0);
    tab[9]  = mk(1, 0, 32'h0,         0, 0, 32'h8,  0, 0, 5'd2, 1, 6'd4, 0, 0);
    tab[10] = mk(1, 0, 32'h0,         0, 0, 32'h10, 0, 0, 5'd4, 1, 6'd4, 0, 0);
    tab[11] = mk(1, 0, 32'h0,         0, 0, 32'h6,  0, 0, 5'd1, 1, 6'd4, 0, 1);
    tab[12] = mk(1, 0, 32'h0,         0, 0, 32'h0,  0, 0, 5'd0, 1, 6'd4, 0, 1);
    tab[13] = mk(1, 0, 32'h0,         0, 1, 32'h0,  0, 0, 5'd0, 1, 6'd4, 0, 1);
    tab[14] = mk(1, 1, 32'hAAAA_0001, 0, 0, 32'h0,  1, 1, 5'd0, 0, 6'd0, 0, 0);
    tab[15] = mk(1, 1, 32'hAAAA_0002, 1, 0, 32'h0,  1, 1, 5'd1, 0, 6'd0, 0, 0);
    tab[16] = mk(1, 0, 32'h0,         0, 0, 32'h4,  0, 0, 5'd1, 1, 6'd2, 0, 0);
    tab[17] = mk(1, 0, 32'h0,         0, 0, 32'h0,  0, 0, 5'd0, 1, 6'd2, 0, 0);

    for (int i = 0; i < 18; i++) begin
      drive(tab[i].rst_n, tab[i].valid, tab[i].data, tab[i].last, tab[i].rl, tab[i].pcv);
      #2;
      chk($sformatf("t%0d_ld_ready", i), W'(ld_ready), W'(tab[i].e_ready));
      chk($sformatf("t%0d_mem_we", i), W'(mem_we), W'(tab[i].e_we));
      chk($sformatf("t%0d_mem_addr", i), W'(mem_addr), W'(tab[i].e_addr));
      chk($sformatf("t%0d_cpu_run", i), W'(cpu_run), W'(tab[i].e_run));
      chk($sformatf("t%0d_word_count", i), W'(word_count), W'(tab[i].e_wc));
      chk($sformatf("t%0d_load_err", i), W'(load_err), W'(tab[i].e_err));
      chk($sformatf("t%0d_fetch_fault", i), W'(fetch_fault), W'(tab[i].e_ff));
      check_model();
      advance();
    end
    chk("reload_word0", imem[0], 32'hAAAA_0001);
    chk("reload_word1", imem[1], 32'hAAAA_0002);
    chk("normal_word2", imem[2], 32'h0109_5020);
    chk("normal_word3", imem[3], 32'h0800_0000);

    // Overflow: 32 beats without last, then a 33rd beat that must be refused.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < D; i++) cyc(1'b1, 1'b1, 32'hC0DE_0000 + W'(i), 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    #2;
    chk("ovf_load_err", W'(load_err), 32'h1);
    chk("ovf_ld_ready", W'(ld_ready), 32'h0);
    chk("ovf_33rd_we", W'(mem_we), 32'h0);
    chk("ovf_cpu_run", W'(cpu_run), 32'h0);
    check_model();
    advance();
    chk("ovf_word31", imem[31], 32'hC0DE_001F);
    chk("ovf_word0", imem[0], 32'hC0DE_0000);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    chk("err_cleared", W'(load_err), 32'h0);

    // Single-word program, then fetch one word past the end.
    cyc(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
    chk("single_run", W'(cpu_run), 32'h1);
    chk("single_wc", W'(word_count), 32'h1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4);
    chk("single_fault", W'(fetch_fault), 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rp = W'($urandom_range(0, 47));
      if ($urandom_range(0, 3) != 0) rp = rp & 32'hFFFF_FFFC;
      if ($urandom_range(0, 31) == 0) rp = $urandom;
      cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 1) == 1), $urandom,
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0), rp);
    end
    for (int i = 0; i < D; i++) chk($sformatf("mem_%0d", i), imem[i], exp_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
